// File: rtl/aud_recorder.sv
// I2S ADC-side receiver: deserialises one channel of audio from ADCDAT and hands each
// completed word to the recording controller over a valid/ack handshake.
module aud_recorder #(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_adclrck,
    input  logic              i_en,
    input  logic              i_adcdat,
    input  logic              i_ack,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_ovr,
    output logic              o_frame_err,
    output logic [15:0]       o_word_cnt
);

    localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic            ChanLvl = (CHANNEL != 0);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRecv
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic                lrc_q, lrc_d;

    logic                phase_start;
    logic [DATA_W-1:0]   shift_nxt;

    // The phase-start edge is the I2S one-bit delay slot; data starts on the next edge.
    assign phase_start = (i_adclrck == ChanLvl) && (lrc_q != ChanLvl);
    assign shift_nxt   = (shift_q << 1) | {{(DATA_W-1){1'b0}}, i_adcdat};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        frame_err_d = frame_err_q;
        word_cnt_d  = word_cnt_q;
        lrc_d       = i_adclrck;

        if (i_clr_err) begin
            ovr_d       = 1'b0;
            frame_err_d = 1'b0;
        end
        if (i_ack) begin
            valid_d = 1'b0;
        end

        // Set events below override the clears above.
        unique case (state_q)
            StIdle: begin
                if (i_en) begin
                    state_d    = StWait;
                    word_cnt_d = '0;
                end
            end
            StWait: begin
                if (!i_en) begin
                    state_d = StIdle;
                end else if (phase_start) begin
                    state_d = StRecv;
                    cnt_d   = '0;
                end
            end
            StRecv: begin
                if (i_adclrck != ChanLvl) begin
                    state_d     = StWait;
                    frame_err_d = 1'b1;
                end else begin
                    shift_d = shift_nxt;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        data_d     = shift_nxt;
                        valid_d    = 1'b1;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (valid_q && !i_ack) begin
                            ovr_d = 1'b1;
                        end
                        state_d = i_en ? StWait : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            frame_err_q <= 1'b0;
            word_cnt_q  <= '0;
            lrc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            frame_err_q <= frame_err_d;
            word_cnt_q  <= word_cnt_d;
            lrc_q       <= lrc_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_ovr       = ovr_q;
    assign o_frame_err = frame_err_q;
    assign o_word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder (left channel): expected words are queued as frames are
// sent and popped when the receiver presents them.
module tb_aud_recorder;

    logic        i_bclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_adclrck = 1'b1;
    logic        i_en = 1'b0;
    logic        i_adcdat = 1'b0;
    logic        i_ack = 1'b0;
    logic        i_clr_err = 1'b0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_ovr;
    logic        o_frame_err;
    logic [15:0] o_word_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    aud_recorder #(
        .CHANNEL(0),
        .DATA_W (16)
    ) dut (
        .i_bclk     (i_bclk),
        .i_rst_n    (i_rst_n),
        .i_adclrck  (i_adclrck),
        .i_en       (i_en),
        .i_adcdat   (i_adcdat),
        .i_ack      (i_ack),
        .i_clr_err  (i_clr_err),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ovr      (o_ovr),
        .o_frame_err(o_frame_err),
        .o_word_cnt (o_word_cnt)
    );

    always #5 i_bclk = ~i_bclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the negedge and are sampled by the next posedge; returns at the
    // following negedge where the effect of that posedge is visible.
    task automatic step(input logic lvl, input logic d);
        i_adclrck = lvl;
        i_adcdat  = d;
        @(negedge i_bclk);
    endtask

    task automatic pad(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    // Delay slot then nbits MSB-first bits of w.
    task automatic send_bits(input logic lvl, input logic [15:0] w, input int nbits,
                             input int en_drop_at, input bit ack_last);
        step(lvl, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == en_drop_at) i_en = 1'b0;
            if (ack_last && i == nbits - 1) i_ack = 1'b1;
            step(lvl, w[15-i]);
            i_ack = 1'b0;
        end
    endtask

    task automatic right_phase();
        send_bits(1'b1, 16'hFFFF, 16, -1, 1'b0);
        pad(1'b1, 2);
    endtask

    task automatic check_word(input string tag);
        logic [15:0] exp;
        check({tag, "_valid"}, 16'(o_valid), 16'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_data observed %h expected <queue empty>", tag, o_data);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, o_data, exp);
        end
    endtask

    task automatic ack_pulse(input logic lvl);
        i_ack = 1'b1;
        step(lvl, 1'b0);
        i_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge i_bclk);
        @(negedge i_bclk);
        check("rst_data", o_data, 16'h0000);
        check("rst_valid", 16'(o_valid), 16'd0);
        check("rst_ovr", 16'(o_ovr), 16'd0);
        check("rst_ferr", 16'(o_frame_err), 16'd0);
        check("rst_cnt", o_word_cnt, 16'd0);
        i_rst_n = 1'b1;

        // Basic left-channel capture; right word ignored.
        i_en = 1'b1;
        pad(1'b1, 3);
        exp_q.push_back(16'hA5C3);
        send_bits(1'b0, 16'hA5C3, 16, -1, 1'b0);
        check_word("t1");
        check("t1_cnt", o_word_cnt, 16'd1);
        pad(1'b0, 3);
        right_phase();
        check("t1_right_data", o_data, 16'hA5C3);
        check("t1_right_cnt", o_word_cnt, 16'd1);
        ack_pulse(1'b1);
        check("t1_ack", 16'(o_valid), 16'd0);

        // Enable mid left phase: partial frame skipped.
        i_en = 1'b0;
        step(1'b1, 1'b0);
        check("t2_cnt_hold", o_word_cnt, 16'd1);
        pad(1'b0, 3);
        i_en = 1'b1;
        step(1'b0, 1'b1);
        check("t2_cnt_clr", o_word_cnt, 16'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        right_phase();
        check("t2_partial", 16'(o_valid), 16'd0);
        exp_q.push_back(16'h8001);
        send_bits(1'b0, 16'h8001, 16, -1, 1'b0);
        check_word("t2");
        check("t2_cnt", o_word_cnt, 16'd1);
        pad(1'b0, 2);

        // Overrun then clear.
        ack_pulse(1'b0);
        right_phase();
        exp_q.push_back(16'h1111);
        send_bits(1'b0, 16'h1111, 16, -1, 1'b0);
        check_word("t3a");
        check("t3a_ovr", 16'(o_ovr), 16'd0);
        pad(1'b0, 2);
        right_phase();
        exp_q.push_back(16'h2222);
        send_bits(1'b0, 16'h2222, 16, -1, 1'b0);
        check_word("t3b");
        check("t3_ovr", 16'(o_ovr), 16'd1);
        check("t3_cnt", o_word_cnt, 16'd3);
        i_clr_err = 1'b1;
        step(1'b0, 1'b0);
        i_clr_err = 1'b0;
        check("t3_ovr_clr", 16'(o_ovr), 16'd0);
        check("t3_valid_kept", 16'(o_valid), 16'd1);

        // Ack on the completing edge: new word, no overrun.
        right_phase();
        exp_q.push_back(16'h3C3C);
        send_bits(1'b0, 16'h3C3C, 16, -1, 1'b1);
        check_word("t4");
        check("t4_ovr", 16'(o_ovr), 16'd0);
        check("t4_cnt", o_word_cnt, 16'd4);
        ack_pulse(1'b0);

        // Short frame; set beats a simultaneous clear.
        right_phase();
        send_bits(1'b0, 16'hFFFF, 10, -1, 1'b0);
        i_clr_err = 1'b1;
        step(1'b1, 1'b0);
        i_clr_err = 1'b0;
        check("t5_ferr", 16'(o_frame_err), 16'd1);
        check("t5_valid", 16'(o_valid), 16'd0);
        check("t5_cnt", o_word_cnt, 16'd4);
        pad(1'b1, 16);
        exp_q.push_back(16'h5A5A);
        send_bits(1'b0, 16'h5A5A, 16, -1, 1'b0);
        check_word("t5");
        check("t5_cnt2", o_word_cnt, 16'd5);
        check("t5_ferr_sticky", 16'(o_frame_err), 16'd1);
        i_clr_err = 1'b1;
        step(1'b0, 1'b0);
        i_clr_err = 1'b0;
        check("t5_ferr_clr", 16'(o_frame_err), 16'd0);

        // Async reset mid-word (o_valid still set with 0x5A5A).
        right_phase();
        send_bits(1'b0, 16'h1234, 7, -1, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check("t6_data", o_data, 16'h0000);
        check("t6_valid", 16'(o_valid), 16'd0);
        check("t6_cnt", o_word_cnt, 16'd0);
        @(negedge i_bclk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
        check("t6_no_partial", 16'(o_valid), 16'd0);
        right_phase();
        exp_q.push_back(16'h7FFF);
        send_bits(1'b0, 16'h7FFF, 16, -1, 1'b0);
        check_word("t6");
        check("t6_cnt2", o_word_cnt, 16'd1);
        ack_pulse(1'b0);

        // Enable dropped at bit 8: word completes, then idle.
        right_phase();
        exp_q.push_back(16'h1234);
        send_bits(1'b0, 16'h1234, 16, 8, 1'b0);
        check_word("t7");
        check("t7_cnt", o_word_cnt, 16'd2);
        ack_pulse(1'b0);
        right_phase();
        send_bits(1'b0, 16'h4321, 16, -1, 1'b0);
        check("t7_idle_valid", 16'(o_valid), 16'd0);
        check("t7_idle_cnt", o_word_cnt, 16'd2);
        i_en = 1'b1;
        step(1'b0, 1'b0);
        check("t7_reen_cnt", o_word_cnt, 16'd0);
        check("t7_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
